// File: rtl/coproc_ctrl.sv
// coproc_ctrl: debug/fault-injection controller that stalls the decoder, drains, then soft-resets, injects or halts
// Ports: cmdValid/cmdReady/cmdOp/cmdReg/cmdMask host command handshake; coprocessorStall/softReset to the pipeline;
//   faultRegAddr/regReadData/faultWriteData/faultWriteEnable register file port; done/cmdError one-cycle pulses;
//   injectCount saturating count of completed injections.
// COPROC_FAULT_INJECT_EN enables op 10 (inject); when undefined op 10 is always rejected with cmdError.
module coproc_ctrl #(
  parameter int XLEN = 64,
  parameter int DRAIN_CYCLES = 5,
  parameter int RESET_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmdValid,
  output logic            cmdReady,
  input  logic [1:0]      cmdOp,
  input  logic [4:0]      cmdReg,
  input  logic [XLEN-1:0] cmdMask,
  input  logic [XLEN-1:0] regReadData,
  output logic            coprocessorStall,
  output logic            softReset,
  output logic [4:0]      faultRegAddr,
  output logic [XLEN-1:0] faultWriteData,
  output logic            faultWriteEnable,
  output logic            done,
  output logic            cmdError,
  output logic [7:0]      injectCount
);
`ifdef COPROC_FAULT_INJECT_EN
  localparam bit INJ_EN = 1'b1;
`else
  localparam bit INJ_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, DRAIN, SRESET, INJECT, RELEASE, HALTED} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [4:0] reg_q, reg_d;
  logic [XLEN-1:0] mask_q, mask_d;
  logic [3:0] cnt_q, cnt_d;
  logic from_halt_q, from_halt_d, done_q, done_d, err_q, err_d;
  logic acc, bad;
  always_comb begin
    acc = cmdValid && cmdReady;
    bad = cmdOp == 2'b10 && (cmdReg == 5'd0 || !INJ_EN);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (acc && cmdOp != 2'b00 && !bad) ? DRAIN : IDLE;
      DRAIN:   state_d = cnt_q != 4'(DRAIN_CYCLES - 1) ? DRAIN : op_q == 2'b01 ? SRESET : op_q == 2'b10 ? INJECT : HALTED;
      SRESET:  state_d = cnt_q == 4'(RESET_CYCLES - 1) ? RELEASE : SRESET;
      INJECT:  state_d = RELEASE;
      RELEASE: state_d = (from_halt_q && op_q != 2'b11) ? HALTED : IDLE;
      HALTED:  state_d = (!acc || cmdOp == 2'b00 || bad) ? HALTED : cmdOp == 2'b01 ? SRESET : cmdOp == 2'b10 ? INJECT : RELEASE;
      default: state_d = IDLE;
    endcase
    // the counter restarts on every state change so DRAIN and SRESET each count from zero
    cnt_d = (state_d == state_q && (state_q == DRAIN || state_q == SRESET)) ? cnt_q + 4'd1 : 4'd0;
    op_d = acc ? cmdOp : op_q;
    reg_d = acc ? cmdReg : reg_q;
    mask_d = acc ? cmdMask : mask_q;
    from_halt_d = acc ? state_q == HALTED : from_halt_q;
    done_d = (acc && cmdOp == 2'b00) || state_d == RELEASE || (state_q == DRAIN && state_d == HALTED);
    err_d = acc && bad;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      op_q <= '0;
      reg_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      from_halt_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      reg_q <= reg_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      from_halt_q <= from_halt_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign cmdReady = state_q == IDLE || state_q == HALTED;
  assign coprocessorStall = state_q != IDLE;
  assign softReset = state_q == SRESET;
  assign faultRegAddr = reg_q;
  assign faultWriteData = regReadData ^ mask_q;
  assign done = done_q;
  assign cmdError = err_q;
`ifdef COPROC_FAULT_INJECT_EN
  logic [7:0] inj_q, inj_d;
  always_comb inj_d = (state_q == INJECT && inj_q != 8'hFF) ? inj_q + 8'd1 : inj_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) inj_q <= '0;
    else inj_q <= inj_d;
  assign faultWriteEnable = state_q == INJECT;
  assign injectCount = inj_q;
`else
  assign faultWriteEnable = 1'b0;
  assign injectCount = 8'd0;
`endif
endmodule

// File: tb/tb_coproc_ctrl.sv
// tb_coproc_ctrl: table-driven and sequence checks of coproc_ctrl with a command scoreboard
module tb_coproc_ctrl;
  localparam int D = 5;
  localparam int R = 4;
  localparam int W = D + R + 4;
`ifdef COPROC_FAULT_INJECT_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif
  logic clk, reset_n, cmdValid, cmdReady, coprocessorStall, softReset, faultWriteEnable, done, cmdError;
  logic [1:0] cmdOp;
  logic [4:0] cmdReg, faultRegAddr;
  logic [63:0] cmdMask, regReadData, faultWriteData;
  logic [7:0] injectCount;
  coproc_ctrl #(.XLEN(64), .DRAIN_CYCLES(D), .RESET_CYCLES(R)) dut (
    .clk(clk), .reset_n(reset_n), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdReg(cmdReg), .cmdMask(cmdMask), .regReadData(regReadData), .coprocessorStall(coprocessorStall),
    .softReset(softReset), .faultRegAddr(faultRegAddr), .faultWriteData(faultWriteData),
    .faultWriteEnable(faultWriteEnable), .done(done), .cmdError(cmdError), .injectCount(injectCount)
  );
  typedef struct {
    logic [1:0] op;
    logic [4:0] rg;
    logic [63:0] mk, rd;
    int e_err, e_done, e_wr;
    logic [63:0] e_wdata;
    int e_stall, e_srst, e_srst_n, e_ready, e_end, win, hold;
  } vec_t;
  typedef struct {
    int done_at, done_n, err_at, err_n, wr_at, wr_n, stall_n, srst_at, srst_n, ready_n, end_stall;
    logic [63:0] wr_data;
    logic [4:0] wr_addr;
  } obs_t;
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  vec_t sb[$];
  vec_t tbl[8];
  vec_t hs[6];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t v(input logic [1:0] op, input logic [4:0] rg, input logic [63:0] mk, rd,
                             input int er, dn, wr, input logic [63:0] wd,
                             input int st, sa, sn, rdy, en, w, h);
    vec_t x;
    x.op = op; x.rg = rg; x.mk = mk; x.rd = rd;
    x.e_err = er; x.e_done = dn; x.e_wr = wr; x.e_wdata = wd;
    x.e_stall = st; x.e_srst = sa; x.e_srst_n = sn; x.e_ready = rdy; x.e_end = en;
    x.win = w; x.hold = h;
    return x;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic issue(input vec_t e, output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    chk("ready_at_issue", 64'(cmdReady), 64'd1);
    cmdValid = 1'b1; cmdOp = e.op; cmdReg = e.rg; cmdMask = e.mk; regReadData = e.rd;
    for (int k = 1; k <= e.win; k++) begin
      @(negedge clk);
      if (k == e.hold) cmdValid = 1'b0;
      if (done) begin o.done_n += 1; if (o.done_at == 0) o.done_at = k; end
      if (cmdError) begin o.err_n += 1; if (o.err_at == 0) o.err_at = k; end
      if (faultWriteEnable) begin
        o.wr_n += 1;
        if (o.wr_at == 0) begin o.wr_at = k; o.wr_data = faultWriteData; o.wr_addr = faultRegAddr; end
      end
      if (softReset) begin o.srst_n += 1; if (o.srst_at == 0) o.srst_at = k; end
      if (coprocessorStall) o.stall_n += 1;
      if (cmdReady) o.ready_n += 1;
      o.end_stall = int'(coprocessorStall);
    end
  endtask
  task automatic run(input string nm, input vec_t e);
    obs_t o;
    vec_t x;
    sb.push_back(e);
    issue(e, o);
    x = sb.pop_front();
    chk({nm, "_err_at"}, 64'(o.err_at), 64'(x.e_err));
    chk({nm, "_err_n"}, 64'(o.err_n), 64'(x.e_err != 0));
    chk({nm, "_done_at"}, 64'(o.done_at), 64'(x.e_done));
    chk({nm, "_done_n"}, 64'(o.done_n), 64'(x.e_done != 0));
    chk({nm, "_wr_at"}, 64'(o.wr_at), 64'(x.e_wr));
    chk({nm, "_wr_n"}, 64'(o.wr_n), 64'(x.e_wr != 0));
    if (x.e_wr != 0) begin
      chk({nm, "_wr_data"}, o.wr_data, x.e_wdata);
      chk({nm, "_wr_addr"}, 64'(o.wr_addr), 64'(x.rg));
      if (exp_cnt < 255) exp_cnt++;
    end
    chk({nm, "_stall_n"}, 64'(o.stall_n), 64'(x.e_stall));
    chk({nm, "_srst_at"}, 64'(o.srst_at), 64'(x.e_srst));
    chk({nm, "_srst_n"}, 64'(o.srst_n), 64'(x.e_srst_n));
    chk({nm, "_ready_n"}, 64'(o.ready_n), 64'(x.e_ready));
    chk({nm, "_end_stall"}, 64'(o.end_stall), 64'(x.e_end));
    chk({nm, "_inj_cnt"}, 64'(injectCount), 64'(exp_cnt));
  endtask
  initial begin
    reset_n = 1'b0; cmdValid = 1'b0; cmdOp = '0; cmdReg = '0; cmdMask = '0; regReadData = '0;
    tbl[0] = v(2'b00, 5'd0, 64'h0, 64'h0, 0, 1, 0, 64'h0, 0, 0, 0, W, 0, W, 1);
    tbl[1] = v(2'b01, 5'd0, 64'h0, 64'h0, 0, D+R+1, 0, 64'h0, D+R+1, D+1, R, 3, 0, W, 1);
    tbl[2] = v(2'b10, 5'd7, 64'h1, 64'hF0, INJ ? 0 : 1, INJ ? D+2 : 0, INJ ? D+1 : 0, 64'hF1,
               INJ ? D+2 : 0, 0, 0, INJ ? W-D-2 : W, 0, W, 1);
    tbl[3] = v(2'b10, 5'd0, 64'h1, 64'hF0, 1, 0, 0, 64'h0, 0, 0, 0, W, 0, W, 1);
    tbl[4] = v(2'b10, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, INJ ? 0 : 1, INJ ? D+2 : 0,
               INJ ? D+1 : 0, 64'hFEDC_BA98_7654_3210, INJ ? D+2 : 0, 0, 0, INJ ? W-D-2 : W, 0, W, 1);
    tbl[5] = v(2'b01, 5'd9, 64'h55, 64'h0, 0, D+R+1, 0, 64'h0, D+R+1, D+1, R, 3, 0, W, 1);
    tbl[6] = v(2'b10, 5'd0, 64'hFF, 64'h1, 1, 0, 0, 64'h0, 0, 0, 0, W, 0, W, 1);
    tbl[7] = v(2'b10, 5'd1, 64'h8000_0000_0000_0000, 64'h0, INJ ? 0 : 1, INJ ? D+2 : 0, INJ ? D+1 : 0,
               64'h8000_0000_0000_0000, INJ ? D+2 : 0, 0, 0, INJ ? W-D-2 : W, 0, W, 1);
    hs[0] = v(2'b11, 5'd0, 64'h0, 64'h0, 0, D+1, 0, 64'h0, D+2, 0, 0, 2, 1, D+2, 1);
    hs[1] = v(2'b10, 5'd5, 64'hFF00, 64'h1234, INJ ? 0 : 1, INJ ? 2 : 0, INJ ? 1 : 0, 64'hED34,
              4, 0, 0, INJ ? 2 : 4, 1, 4, 1);
    hs[2] = v(2'b10, 5'd0, 64'h1, 64'h0, 1, 0, 0, 64'h0, 2, 0, 0, 2, 1, 2, 1);
    hs[3] = v(2'b00, 5'd0, 64'h0, 64'h0, 0, 1, 0, 64'h0, 3, 0, 0, 3, 1, 3, 1);
    hs[4] = v(2'b01, 5'd0, 64'h0, 64'h0, 0, R+1, 0, 64'h0, R+2, 1, R, 1, 1, R+2, 1);
    hs[5] = v(2'b11, 5'd0, 64'h0, 64'h0, 0, 1, 0, 64'h0, 1, 0, 0, 2, 0, 3, 1);
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(coprocessorStall), 64'd0);
    chk("rst_srst", 64'(softReset), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(cmdError), 64'd0);
    chk("rst_wen", 64'(faultWriteEnable), 64'd0);
    chk("rst_addr", 64'(faultRegAddr), 64'd0);
    chk("rst_cnt", 64'(injectCount), 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) run($sformatf("tbl%0d", i), tbl[i]);
    for (int i = 0; i < 6; i++) run($sformatf("halt%0d", i), hs[i]);
    run("b2b", v(2'b01, 5'd0, 64'h0, 64'h0, 0, D+R+1, 0, 64'h0, D+R+1, D+1, R, 2, 0, D+R+3, D+R+2));
    run("pre_arst", v(2'b01, 5'd0, 64'h0, 64'h0, 0, 0, 0, 64'h0, D+2, D+1, 2, 0, 1, D+2, 1));
    chk("arst_srst_before", 64'(softReset), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_stall", 64'(coprocessorStall), 64'd0);
    chk("arst_srst", 64'(softReset), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_err", 64'(cmdError), 64'd0);
    exp_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", 64'(cmdReady), 64'd1);
    chk("arst_cnt", 64'(injectCount), 64'd0);
`ifdef COPROC_FAULT_INJECT_EN
    for (int i = 0; i < 255; i++)
      run("sat", v(2'b10, 5'd3, 64'h1, 64'h0, 0, D+2, D+1, 64'h1, D+2, 0, 0, 0, 1, D+2, 1));
    chk("sat_cnt_255", 64'(injectCount), 64'd255);
    run("sat256", v(2'b10, 5'd3, 64'h2, 64'h1, 0, D+2, D+1, 64'h3, D+2, 0, 0, 0, 1, D+2, 1));
    chk("sat_cnt_hold", 64'(injectCount), 64'd255);
`else
    run("noinj", v(2'b10, 5'd3, 64'h1, 64'h0, 1, 0, 0, 64'h0, 0, 0, 0, 3, 0, 3, 1));
    chk("noinj_cnt", 64'(injectCount), 64'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
